// File: rtl/frame_cfg_pkg.sv
// Shared constants and state encoding for the configuration frame writer.
package frame_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
  localparam logic [7:0]  HDR_TAG     = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StHdr    = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StLoad   = 3'd3;
  localparam state_t StStrobe = 3'd4;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a frame index plus enable into a one-hot write strobe.
module frame_strobe_decoder #(
  parameter int unsigned Width = 20
) (
  input  logic [7:0]       index,
  input  logic             enable,
  output logic [Width-1:0] strobe
);

  always_comb begin
    strobe = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (enable && (index == 8'(i))) strobe[i] = 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Parses a SYNC/header/data word stream and writes one frame per data word into
// the column config memories through a one-hot strobe.
module config_frame_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                WordData,
  input  logic                       WordValid,
  output logic                       WordReady,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Active,
  output logic [15:0]                FrameCount,
  output logic                       Error
);

  state_t                     state_q, state_d;
  logic [7:0]                 index_q, index_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [15:0]                count_q, count_d;
  logic                       error_q, error_d;
  logic                       xfer;
  logic                       header_ok;

  assign WordReady = !RESET &&
                     ((state_q == StIdle) || (state_q == StHdr) || (state_q == StData));
  assign xfer      = WordValid && WordReady;
  assign header_ok = (WordData[31:24] == HDR_TAG) &&
                     (32'(WordData[7:0]) < MaxFramesPerCol);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      StIdle: begin
        if (xfer && (WordData == SYNC_WORD)) state_d = StHdr;
      end
      StHdr: begin
        if (xfer) begin
          if (WordData == DESYNC_WORD) begin
            state_d = StIdle;
          end else if (WordData == SYNC_WORD) begin
            state_d = StHdr;
          end else if (header_ok) begin
            index_d = WordData[7:0];
            state_d = StData;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      // Any word here is payload, even one that looks like SYNC or DESYNC.
      StData: begin
        if (xfer) begin
          data_d  = WordData[FrameBitsPerRow-1:0];
          state_d = StLoad;
        end
      end
      StLoad: state_d = StStrobe;
      StStrobe: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = StHdr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      index_q <= '0;
      data_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  // Gating with RESET keeps a strobe from escaping in the reset cycle itself.
  frame_strobe_decoder #(
    .Width(MaxFramesPerCol)
  ) u_decoder (
    .index (index_q),
    .enable((state_q == StStrobe) && !RESET),
    .strobe(FrameStrobe)
  );

  assign FrameData  = data_q;
  assign Active     = (state_q != StIdle);
  assign FrameCount = count_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Scenario bench: expected strobes are queued when data words are sent and popped by a monitor.
module tb_config_frame_writer;

  localparam int unsigned NF = 20;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [31:0]   WordData = '0;
  logic          WordValid = 1'b0;
  logic          WordReady;
  logic [31:0]   FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          Active;
  logic [15:0]   FrameCount;
  logic          Error;

  typedef struct {
    logic [NF-1:0] strobe;
    logic [31:0]   data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  config_frame_writer #(
    .MaxFramesPerCol(NF),
    .FrameBitsPerRow(32)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .WordData   (WordData),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .Active     (Active),
    .FrameCount (FrameCount),
    .Error      (Error)
  );

  // Monitor: every strobe must be one-hot and match the oldest queued expectation.
  always @(negedge CLK) begin
    if (FrameStrobe !== '0) begin
      checks++;
      if ($countones(FrameStrobe) != 1) begin
        errors++;
        $display("FAIL strobe_onehot: got %h required one bit set", FrameStrobe);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %h required 0", FrameStrobe);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (FrameStrobe !== e.strobe || FrameData !== e.data) begin
          errors++;
          $display("FAIL strobe_frame: got strobe %h data %h required strobe %h data %h",
                   FrameStrobe, FrameData, e.strobe, e.data);
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    WordData = d;
    WordValid = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (WordReady === 1'b1) begin
        @(posedge CLK);
        #1;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: word %h not accepted within 20 cycles", d);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send(input logic [31:0] d);
    int w;
    send_word(d, w);
  endtask

  task automatic push_exp(input int idx, input logic [31:0] d);
    exp_t e;
    e.strobe = '0;
    e.strobe[idx] = 1'b1;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    WordValid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d pending strobes required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    WordValid = 1'b0;
    RESET = 1'b1;
    sb.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (WordReady !== 1'b0 || FrameData !== '0 || FrameStrobe !== '0 || Active !== 1'b0 ||
        FrameCount !== 16'd0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy %b fd %h st %h act %b cnt %0d err %b required 0s",
               WordReady, FrameData, FrameStrobe, Active, FrameCount, Error);
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic test_basic_frame();
    test_reset();
    send(32'hFAB0_FAB1);
    send(32'hA500_0003);
    push_exp(3, 32'h1234_5678);
    send(32'h1234_5678);
    WordValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (FrameData !== 32'h1234_5678 || FrameStrobe !== '0) begin
      errors++;
      $display("FAIL basic_load: got fd %h st %h required fd 12345678 st 0", FrameData,
               FrameStrobe);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (FrameCount !== 16'd1 || Active !== 1'b1) begin
      errors++;
      $display("FAIL basic_count: got cnt %0d act %b required cnt 1 act 1", FrameCount, Active);
    end
    check_drained("basic");
  endtask

  task automatic test_idle_discard();
    test_reset();
    send(32'hA500_0001);
    idle_cycles(4);
    checks++;
    if (Active !== 1'b0 || FrameCount !== 16'd0) begin
      errors++;
      $display("FAIL idle_discard: got act %b cnt %0d required act 0 cnt 0", Active, FrameCount);
    end
    check_drained("idle");
  endtask

  task automatic test_bad_header();
    test_reset();
    send(32'hFAB0_FAB1);
    send(32'hA500_0014);
    WordValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (Error !== 1'b1 || Active !== 1'b1) begin
      errors++;
      $display("FAIL bad_header: got err %b act %b required err 1 act 1", Error, Active);
    end
    send(32'hFAB0_FAB1);
    send(32'hA500_0000);
    push_exp(0, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF);
    idle_cycles(3);
    checks++;
    if (Error !== 1'b1 || FrameCount !== 16'd1) begin
      errors++;
      $display("FAIL error_sticky: got err %b cnt %0d required err 1 cnt 1", Error, FrameCount);
    end
    check_drained("bad_header");
  endtask

  task automatic test_sync_as_data();
    test_reset();
    send(32'hFAB0_FAB1);
    send(32'hA500_0002);
    push_exp(2, 32'hFAB0_FAB0);
    send(32'hFAB0_FAB0);
    WordData = 32'hFAB0_FAB0;
    idle_cycles(4);
    checks++;
    if (Active !== 1'b1 || FrameData !== 32'hFAB0_FAB0) begin
      errors++;
      $display("FAIL desync_as_data: got act %b fd %h required act 1 fd fab0fab0", Active,
               FrameData);
    end
    send(32'hFAB0_FAB0);
    WordValid = 1'b0;
    @(negedge CLK);
    checks++;
    if (Active !== 1'b0) begin
      errors++;
      $display("FAIL desync: got act %b required 0", Active);
    end
    check_drained("sync_as_data");
  endtask

  task automatic test_back_to_back();
    int w;
    test_reset();
    send(32'hFAB0_FAB1);
    for (int k = 0; k < 3; k++) begin
      send_word(32'hA500_0005 + 32'(k), w);
      if (k > 0) begin
        checks++;
        if (w != 2) begin
          errors++;
          $display("FAIL b2b_stall: got %0d not-ready cycles required 2", w);
        end
      end
      push_exp(5 + k, 32'hC0DE_0000 + 32'(k));
      send_word(32'hC0DE_0000 + 32'(k), w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL b2b_data_ready: got %0d waits required 0", w);
      end
    end
    idle_cycles(4);
    checks++;
    if (FrameCount !== 16'd3) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 3", FrameCount);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_in_load();
    test_reset();
    send(32'hFAB0_FAB1);
    send(32'hA500_0001);
    send(32'h55AA_55AA);
    WordValid = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (FrameData !== '0 || Active !== 1'b0 || FrameCount !== 16'd0 || FrameStrobe !== '0) begin
      errors++;
      $display("FAIL reset_load: got fd %h act %b cnt %0d st %h required all 0", FrameData,
               Active, FrameCount, FrameStrobe);
    end
    idle_cycles(2);
    check_drained("reset_load");
  endtask

  task automatic test_reset_in_strobe();
    test_reset();
    send(32'hFAB0_FAB1);
    send(32'hA500_0004);
    send(32'h0BAD_F00D);
    WordValid = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (FrameStrobe !== '0) begin
      errors++;
      $display("FAIL reset_strobe: got %h required 0", FrameStrobe);
    end
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (FrameStrobe !== '0 || FrameCount !== 16'd0 || Active !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobe_after: got st %h cnt %0d act %b required 0", FrameStrobe,
               FrameCount, Active);
    end
    idle_cycles(2);
    check_drained("reset_strobe");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_idle_discard();
    test_bad_header();
    test_sync_as_data();
    test_back_to_back();
    test_reset_in_load();
    test_reset_in_strobe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frames per column (range 1..256).
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, width of one frame data word.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port WordData  input  32  incoming configuration word.
REQ-006 SHALL have port WordValid  input  1  WordData is valid.
REQ-007 SHALL have port WordReady  output  1  block accepts a word this cycle; transfer = WordValid & WordReady.
REQ-008 SHALL have port FrameData  output  FrameBitsPerRow  frame data presented to the column config memories.
REQ-009 SHALL have port FrameStrobe  output  MaxFramesPerCol  one-hot write strobe, one bit per frame.
REQ-010 SHALL have port Active  output  1  high while the block is synchronised (any state except IDLE).
REQ-011 SHALL have port FrameCount  output  16  number of frames written since reset.
REQ-012 SHALL have port Error  output  1  sticky bad-header flag.

Function
REQ-013 SHALL implement states IDLE, HDR, DATA, LOAD and STROBE.
REQ-014 IDLE: WordReady=1; accepted word 0xFAB0FAB1 (SYNC) -> HDR; any other accepted word is discarded.
REQ-015 HDR: WordReady=1; accepted 0xFAB0FAB0 (DESYNC) -> IDLE; accepted SYNC -> stay in HDR, ignored.
REQ-016 HDR: accepted header with WordData[31:24]=0xA5 and WordData[7:0] < MaxFramesPerCol -> latch index, go to DATA.
REQ-017 HDR: any other accepted word -> Error set to 1, word discarded, stay in HDR.
REQ-018 DATA: WordReady=1; the next accepted word is always data, including words equal to SYNC or DESYNC; WordData[FrameBitsPerRow-1:0] is registered into FrameData, then -> LOAD.
REQ-019 LOAD: WordReady=0, FrameStrobe=0; FrameData already stable; -> STROBE.
REQ-020 STROBE: WordReady=0; FrameStrobe[index]=1 for exactly this one cycle; FrameCount += 1, saturating at 0xFFFF; -> HDR.
REQ-021 Timing: data word accepted in cycle N gives FrameData new from N+1 and a strobe in cycle N+2; the next word can be accepted from N+3.
REQ-022 FrameData SHALL hold its value until the next data word is accepted; it changes in no other state.
REQ-023 FrameStrobe SHALL be all-zero in every state except STROBE and SHALL never have more than one bit set.
REQ-024 Words presented with WordValid=0 SHALL have no effect in any state.
REQ-025 Error SHALL be cleared only by RESET.

Reset
REQ-026 With RESET=1 at a clock edge, the block SHALL go to IDLE with FrameData=0, FrameStrobe=0, FrameCount=0, Error=0, Active=0, and the latched index=0.
REQ-027 RESET in any state, including LOAD and STROBE, SHALL suppress any pending strobe; no strobe SHALL be issued in the reset cycle or the cycle after it.
REQ-028 WordReady SHALL be 0 while RESET=1.

Structure
REQ-029 Package frame_cfg_pkg SHALL hold SYNC_WORD, DESYNC_WORD, HDR_TAG (0xA5) and the state enumeration.
REQ-030 One sub-module, frame_strobe_decoder (index plus enable to a one-hot MaxFramesPerCol-bit vector), is natural; the FSM, registers and counter SHALL stay in config_frame_writer.

Verification
REQ-031 Reset, then words SYNC, 0xA5000003, 0x12345678 -> FrameData=0x12345678 one cycle after the data word, FrameStrobe=0x00008 for one cycle a further cycle later, FrameCount=1.
REQ-032 In IDLE, word 0xA5000001 without SYNC -> discarded, no strobe, Active=0.
REQ-033 SYNC, then 0xA5000014 (index 20, with MaxFramesPerCol=20) -> Error=1, stays in HDR; then 0xA5000000, 0xFFFFFFFF -> FrameStrobe=0x00001 for one cycle, Error still 1.
REQ-034 SYNC, 0xA5000002, data word 0xFAB0FAB0 -> FrameData=0xFAB0FAB0, strobe bit 2, state returns to HDR (not IDLE); then DESYNC -> Active=0.
REQ-035 Hold WordValid=1 continuously through three header/data pairs -> WordReady=0 in LOAD and STROBE only; three single-cycle strobes, FrameCount=3.
REQ-036 Assert RESET in the LOAD cycle -> no strobe, FrameData=0, state IDLE, FrameCount unchanged at 0.
